// File: rtl/tstate_sequencer_if.sv
// Bus-control and datapath-strobe bundle between the T-state sequencer and the 8085 datapath.
// master = sequencer side, slave = datapath / bus side.
interface tstate_sequencer_if;
    logic       ready;
    logic [7:0] ir;
    logic       pc_rw, bc_rw, de_rw, hl_rw;
    logic       dreg_rd, dreg_wr, dreg_inc, dreg_cnt;
    logic       lreg_rd, lreg_wr, rreg_rd, rreg_wr;
    logic       dbus_to_instr_reg;
    logic       write_dbus_to_alu_tmp, dbus_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus;
    logic [2:0] t_state;
    logic [1:0] m_cycle;
    logic       halted, bus_timeout;

    modport master (
        input  ready, ir,
        output pc_rw, bc_rw, de_rw, hl_rw, dreg_rd, dreg_wr, dreg_inc, dreg_cnt,
               lreg_rd, lreg_wr, rreg_rd, rreg_wr, dbus_to_instr_reg,
               write_dbus_to_alu_tmp, dbus_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus,
               t_state, m_cycle, halted, bus_timeout
    );

    modport slave (
        output ready, ir,
        input  pc_rw, bc_rw, de_rw, hl_rw, dreg_rd, dreg_wr, dreg_inc, dreg_cnt,
               lreg_rd, lreg_wr, rreg_rd, rreg_wr, dbus_to_instr_reg,
               write_dbus_to_alu_tmp, dbus_to_act, alu_to_a, sel_alu_a, alu_a_to_dbus,
               t_state, m_cycle, halted, bus_timeout
    );
endinterface

// File: rtl/tstate_sequencer.sv
// 8085 machine-cycle / T-state sequencer: M1 fetch, MOV r,r, MVI r,d8, NOP, HLT.
// Define READY_WAIT_EN to enable ready-driven TW states with WAIT_TIMEOUT bus timeout.
module tstate_sequencer #(
    parameter int unsigned WAIT_TIMEOUT = 8
) (
    input logic          clk,
    input logic          rst_n,
    tstate_sequencer_if.master io_bus
);
    // State encoding doubles as the t_state output code.
    typedef enum logic [2:0] {
        S_RST = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
        S_T4  = 3'd4, S_T5 = 3'd5, S_TW = 3'd6, S_HALT = 3'd7
    } state_t;

    typedef struct packed {
        logic bc, de, hl, hi, lo, a;
    } sel_t;

    function automatic sel_t reg_sel(input logic [2:0] code);
        sel_t s;
        s = '0;
        case (code)
            3'b000: begin s.bc = 1'b1; s.hi = 1'b1; end
            3'b001: begin s.bc = 1'b1; s.lo = 1'b1; end
            3'b010: begin s.de = 1'b1; s.hi = 1'b1; end
            3'b011: begin s.de = 1'b1; s.lo = 1'b1; end
            3'b100: begin s.hl = 1'b1; s.hi = 1'b1; end
            3'b101: begin s.hl = 1'b1; s.lo = 1'b1; end
            3'b111: s.a = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    state_t     r_state;
    logic [1:0] r_mc;
    logic [7:0] r_ir;
    logic       w_mov, w_mvi;
    sel_t       w_src, w_dst;

    // Code 110 (memory operand) in either field falls back to NOP; 76h is caught as HLT first.
    assign w_mov = (io_bus.ir[7:6] == 2'b01) && (io_bus.ir[5:3] != 3'b110) && (io_bus.ir[2:0] != 3'b110);
    assign w_mvi = (io_bus.ir[7:6] == 2'b00) && (io_bus.ir[2:0] == 3'b110) && (io_bus.ir[5:3] != 3'b110);

`ifdef READY_WAIT_EN
    logic [3:0] r_wcnt;
    logic       r_timeout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_mc    <= 2'd0;
            r_ir    <= 8'h00;
`ifdef READY_WAIT_EN
            r_wcnt    <= 4'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef READY_WAIT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_RST: begin
                    r_state <= S_T1;
                    r_mc    <= 2'd1;
                end
                S_T1: begin
                    r_state <= S_T2;
`ifdef READY_WAIT_EN
                    r_wcnt  <= 4'd0;
`endif
                end
`ifdef READY_WAIT_EN
                S_T2: r_state <= io_bus.ready ? S_T3 : S_TW;
                S_TW: begin
                    if (io_bus.ready) begin
                        r_state <= S_T3;
                    end else if (r_wcnt == 4'(WAIT_TIMEOUT - 1)) begin
                        r_state   <= S_T3;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
`else
                S_T2: r_state <= S_T3;
                S_TW: r_state <= S_T3;
`endif
                S_T3: begin
                    if (r_mc == 2'd2) begin
                        r_state <= S_T1;
                        r_mc    <= 2'd1;
                    end else begin
                        r_state <= S_T4;
                    end
                end
                S_T4: begin
                    r_ir <= io_bus.ir;
                    if (io_bus.ir == 8'h76) begin
                        r_state <= S_HALT;
                    end else if (w_mov) begin
                        r_state <= S_T5;
                    end else if (w_mvi) begin
                        r_state <= S_T1;
                        r_mc    <= 2'd2;
                    end else begin
                        r_state <= S_T1;
                    end
                end
                S_T5:    r_state <= S_T1;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Strobes decode the registered state; T4 source reads use ir, which is valid throughout T4.
    always_comb begin
        w_src = reg_sel(io_bus.ir[2:0]);
        w_dst = reg_sel(r_ir[5:3]);
        io_bus.pc_rw = 1'b0;  io_bus.bc_rw = 1'b0;  io_bus.de_rw = 1'b0;  io_bus.hl_rw = 1'b0;
        io_bus.dreg_rd = 1'b0; io_bus.dreg_wr = 1'b0; io_bus.dreg_inc = 1'b0; io_bus.dreg_cnt = 1'b0;
        io_bus.lreg_rd = 1'b0; io_bus.lreg_wr = 1'b0; io_bus.rreg_rd = 1'b0; io_bus.rreg_wr = 1'b0;
        io_bus.dbus_to_instr_reg = 1'b0;
        io_bus.write_dbus_to_alu_tmp = 1'b0;
        io_bus.dbus_to_act = 1'b0;   io_bus.alu_to_a = 1'b0;
        io_bus.sel_alu_a = 1'b0;     io_bus.alu_a_to_dbus = 1'b0;
        case (r_state)
            S_T1: begin
                io_bus.pc_rw = 1'b1; io_bus.dreg_rd = 1'b1;
                io_bus.dreg_inc = 1'b1; io_bus.dreg_cnt = 1'b1;
            end
            S_T3: begin
                if (r_mc == 2'd1) begin
                    io_bus.dbus_to_instr_reg = 1'b1;
                end else begin
                    io_bus.bc_rw = w_dst.bc; io_bus.de_rw = w_dst.de; io_bus.hl_rw = w_dst.hl;
                    io_bus.lreg_wr = w_dst.hi; io_bus.rreg_wr = w_dst.lo;
                    io_bus.dbus_to_act = w_dst.a; io_bus.alu_to_a = w_dst.a;
                end
            end
            S_T4: begin
                if (w_mov) begin
                    io_bus.bc_rw = w_src.bc; io_bus.de_rw = w_src.de; io_bus.hl_rw = w_src.hl;
                    io_bus.lreg_rd = w_src.hi; io_bus.rreg_rd = w_src.lo;
                    io_bus.sel_alu_a = w_src.a; io_bus.alu_a_to_dbus = w_src.a;
                    io_bus.write_dbus_to_alu_tmp = 1'b1;
                end
            end
            S_T5: begin
                io_bus.bc_rw = w_dst.bc; io_bus.de_rw = w_dst.de; io_bus.hl_rw = w_dst.hl;
                io_bus.lreg_wr = w_dst.hi; io_bus.rreg_wr = w_dst.lo;
                io_bus.dbus_to_act = w_dst.a; io_bus.alu_to_a = w_dst.a;
                io_bus.alu_a_to_dbus = 1'b1;
            end
            default: ;
        endcase
        io_bus.t_state = r_state;
        io_bus.m_cycle = r_mc;
        io_bus.halted  = (r_state == S_HALT);
`ifdef READY_WAIT_EN
        io_bus.bus_timeout = r_timeout;
`else
        io_bus.bus_timeout = 1'b0;
`endif
    end
endmodule

// File: tb/tb_tstate_sequencer.sv
// Randomized bench for tstate_sequencer: a per-instruction cycle list built from the
// instruction rules is replayed against the DUT, one record per clock.
module tb_tstate_sequencer;
`ifdef READY_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int TMO = 8;

    // Strobe vector bit positions.
    localparam int PC = 0, BC = 1, DE = 2, HL = 3, DRD = 4, DWR = 5, DINC = 6, DCNT = 7;
    localparam int LRD = 8, LWR = 9, RRD = 10, RWR = 11, IRLD = 12, ATMP = 13;
    localparam int DACT = 14, ALUA = 15, SELA = 16, ADB = 17;

    typedef struct {
        logic [2:0]  t;
        logic [1:0]  m;
        logic [17:0] s;
        logic        to;
        logic        hlt;
        logic        rdy;
        logic [7:0]  ir;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_step = 0;
    rec_t q[$];

    tstate_sequencer_if bus();

    tstate_sequencer #(.WAIT_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    always #5 clk = ~clk;

    logic [17:0] w_obs;
    assign w_obs = {bus.alu_a_to_dbus, bus.sel_alu_a, bus.alu_to_a, bus.dbus_to_act,
                    bus.write_dbus_to_alu_tmp, bus.dbus_to_instr_reg, bus.rreg_wr, bus.rreg_rd,
                    bus.lreg_wr, bus.lreg_rd, bus.dreg_cnt, bus.dreg_inc, bus.dreg_wr, bus.dreg_rd,
                    bus.hl_rw, bus.de_rw, bus.bc_rw, bus.pc_rw};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Register access strobes: pairs B/D/H = codes 0-1/2-3/4-5, even code = high byte.
    function automatic logic [17:0] reg_acc(input int code, input bit wr);
        logic [17:0] v;
        v = '0;
        if (code == 7) begin
            if (wr) begin v[DACT] = 1'b1; v[ALUA] = 1'b1; end
            else    begin v[SELA] = 1'b1; v[ADB] = 1'b1; end
        end else if (code != 6) begin
            v[BC + code / 2] = 1'b1;
            if (code % 2 == 0) v[wr ? LWR : LRD] = 1'b1;
            else               v[wr ? RWR : RRD] = 1'b1;
        end
        return v;
    endfunction

    function automatic void push(input int t, input int m, input logic [17:0] s,
                                 input bit to, input bit hlt, input bit rdy, input logic [7:0] irv);
        rec_t r;
        r.t = 3'(t); r.m = 2'(m); r.s = s; r.to = to; r.hlt = hlt; r.rdy = rdy; r.ir = irv;
        q.push_back(r);
    endfunction

    // One bus cycle: T1, T2, optional TW run, T3 carrying t3s.
    function automatic void bus_cycle(input int m, input int w, input logic [17:0] t3s);
        logic [17:0] fetch;
        int  ntw;
        bit  to;
        fetch = '0;
        fetch[PC] = 1'b1; fetch[DRD] = 1'b1; fetch[DINC] = 1'b1; fetch[DCNT] = 1'b1;
        to  = WAIT_EN && (w >= TMO);
        ntw = !WAIT_EN ? 0 : (to ? TMO : w);
        push(1, m, fetch, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
        push(2, m, '0, 1'b0, 1'b0, WAIT_EN ? (ntw == 0) : 1'($urandom), 8'($urandom));
        for (int k = 1; k <= ntw; k++)
            push(6, m, '0, 1'b0, 1'b0, !to && (k == ntw), 8'($urandom));
        push(3, m, t3s, to, 1'b0, 1'($urandom), 8'($urandom));
    endfunction

    function automatic void build(input logic [7:0] irv, input int w1, input int w2);
        logic [17:0] v;
        int  dst, src;
        bit  is_mov, is_mvi;
        dst = int'(irv[5:3]);
        src = int'(irv[2:0]);
        is_mov = (irv[7:6] == 2'b01) && (src != 6) && (dst != 6);
        is_mvi = (irv[7:6] == 2'b00) && (src == 6) && (dst != 6);
        v = '0; v[IRLD] = 1'b1;
        bus_cycle(1, w1, v);
        v = '0;
        if (is_mov) begin v = reg_acc(src, 1'b0); v[ATMP] = 1'b1; end
        push(4, 1, v, 1'b0, 1'b0, 1'($urandom), irv);
        if (irv == 8'h76) begin
            for (int k = 0; k < 20; k++) push(7, 1, '0, 1'b0, 1'b1, 1'($urandom), 8'($urandom));
        end else if (is_mov) begin
            v = reg_acc(dst, 1'b1); v[ADB] = 1'b1;
            push(5, 1, v, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
        end else if (is_mvi) begin
            bus_cycle(2, w2, reg_acc(dst, 1'b1));
        end
    endfunction

    task automatic play(input int n);
        rec_t r;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            @(negedge clk);
            bus.ready = r.rdy;
            bus.ir    = r.ir;
            #1;
            n_step++;
            chk($sformatf("tstate@%0d", n_step), 32'(bus.t_state), 32'(r.t));
            chk($sformatf("mcycle@%0d", n_step), 32'(bus.m_cycle), 32'(r.m));
            chk($sformatf("strobes@%0d", n_step), 32'(w_obs), 32'(r.s));
            chk($sformatf("halted@%0d", n_step), 32'(bus.halted), 32'(r.hlt));
            chk($sformatf("timeout@%0d", n_step), 32'(bus.bus_timeout), 32'(r.to));
        end
    endtask

    function automatic logic [31:0] all_out();
        return {7'd0, w_obs, bus.t_state, bus.m_cycle, bus.halted, bus.bus_timeout};
    endfunction

    // Called between edges; reset takes effect immediately and is held for 2 clocks.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_assert"}, all_out(), 32'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, all_out(), 32'd0);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic run(input logic [7:0] irv, input int w1, input int w2);
        build(irv, w1, w2);
        play(q.size());
        if (irv == 8'h76) do_reset("halt_exit");
    endtask

    initial begin
        logic [7:0] irv;
        int sel;
        bus.ready = 1'b1;
        bus.ir    = 8'h00;
        #2;
        @(negedge clk);
        do_reset("por");

        run(8'h00, 0, 0);       // NOP, 4T
        run(8'h43, 0, 0);       // MOV B,E
        run(8'h3E, 0, 0);       // MVI A
        run(8'h00, 2, 0);       // 2 wait states when enabled
        run(8'h00, 20, 0);      // M1 timeout
        run(8'h0E, 1, 20);      // MVI C with M2 timeout
        run(8'h7F, 0, 0);       // MOV A,A
        run(8'h40, 0, 0);       // MOV B,B
        run(8'h78, 3, 0);       // MOV A,B
        run(8'h46, 0, 0);       // MOV B,M -> NOP
        run(8'h36, 0, 0);       // MVI M -> NOP
        run(8'h76, 0, 0);       // HLT then reset

        // Reset in M2.T2 of MVI B: no write strobes, restart at M1.T1.
        build(8'h06, 0, 5);
        play(6);
        do_reset("abort_m2");
        run(8'h2E, 0, 0);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            irv = 8'($urandom);
            if (sel <= 3)      irv[7:6] = 2'b01;
            else if (sel <= 6) begin irv[7:6] = 2'b00; irv[2:0] = 3'b110; end
            else if (sel == 7) irv = 8'h00;
            else if (sel == 8 && n % 40 == 0) irv = 8'h76;
            run(irv, ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
